// File: rtl/fx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : fx_pkg                                                   |
// | Purpose   : Shared types and helpers for the fixed-point add/sub     |
// |             family (operation enum, full-precision width helper,     |
// |             range check / clamp function).                           |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package fx_pkg;

   typedef enum logic {
      FX_ADD = 1'b0,
      FX_SUB = 1'b1
   } fx_op_e;

   // Widest value the range helper can handle; supports W_IN up to 29.
   localparam int FX_W_MAX = 32;

   // Full-precision width: one bit for the exact sum, one bit of headroom
   // for the rounding bias.
   function automatic int fx_w_full(input int w_in);
      return w_in + 2;
   endfunction

   // Returns {ovf, value}: value is r clamped to the signed w_out range,
   // ovf is set when r lay outside it.
   function automatic logic [FX_W_MAX:0] fx_sat(
      input logic signed [FX_W_MAX-1:0] r,
      input int                         w_out
   );
      logic signed [FX_W_MAX-1:0] hi;
      logic signed [FX_W_MAX-1:0] lo;
      hi = $signed((FX_W_MAX'(1) << (w_out - 1)) - FX_W_MAX'(1));
      lo = ~hi;
      if (r > hi) begin
         return {1'b1, hi};
      end else if (r < lo) begin
         return {1'b1, lo};
      end
      return {1'b0, r};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fx_addsub_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : fx_addsub_lane                                           |
// | Purpose   : One lane of signed add/sub with round-to-nearest right   |
// |             shift and saturate-or-wrap to W_OUT. Purely comb.        |
// | Ports     : i_a, i_b   signed operands (W_IN)                        |
// |             i_sub      0: a+b, 1: a-b                                |
// |             i_sat_en   1: clamp on overflow, 0: keep low W_OUT bits  |
// |             o_res      result (W_OUT), o_ovf out-of-range flag       |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module fx_addsub_lane
   import fx_pkg::*;
#(
   parameter int W_IN  = 12,
   parameter int W_OUT = 13,
   parameter int SHR   = 0
) (
   input  logic [W_IN-1:0]  i_a,
   input  logic [W_IN-1:0]  i_b,
   input  logic             i_sub,
   input  logic             i_sat_en,
   output logic [W_OUT-1:0] o_res,
   output logic             o_ovf
);

   localparam int W_FULL = fx_w_full(W_IN);

   fx_op_e                   w_op;
   logic signed [W_FULL-1:0] w_a;
   logic signed [W_FULL-1:0] w_b;
   logic signed [W_FULL-1:0] w_s;
   logic signed [W_FULL-1:0] w_r;
   logic [FX_W_MAX:0]        w_sat;
   logic                     w_unused_sat;

   assign w_op = fx_op_e'(i_sub);
   assign w_a  = {{2{i_a[W_IN-1]}}, i_a};
   assign w_b  = {{2{i_b[W_IN-1]}}, i_b};
   assign w_s  = (w_op == FX_SUB) ? (w_a - w_b) : (w_a + w_b);

   generate
      if (SHR > 0) begin : g_round
         // Adding half an LSB before the arithmetic shift rounds ties
         // toward +inf.
         localparam logic signed [W_FULL-1:0] c_half = W_FULL'(1) << (SHR - 1);
         logic signed [W_FULL-1:0] w_biased;
         assign w_biased = w_s + c_half;
         assign w_r      = w_biased >>> SHR;
      end else begin : g_noround
         assign w_r = w_s;
      end
   endgenerate

   assign w_sat = fx_sat({{(FX_W_MAX-W_FULL){w_r[W_FULL-1]}}, w_r}, W_OUT);

   // In range the clamped and raw values coincide, so the select only
   // matters for overflowing results.
   assign o_ovf = w_sat[FX_W_MAX];
   assign o_res = i_sat_en ? w_sat[W_OUT-1:0] : w_r[W_OUT-1:0];

   assign w_unused_sat = ^w_sat[FX_W_MAX-1:W_OUT];

endmodule
`default_nettype wire

// File: rtl/fx_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : fx_addsub_pipe                                           |
// | Purpose   : NCH lanes of signed add/sub sharing one valid/ready      |
// |             handshake, LAT-deep pipeline with global stall.          |
// | Ports     : clk, rst_n (sync, active-low)                            |
// |             in_valid/in_ready, op_sub, sat_en, i_data_1, i_data_2    |
// |             out_valid/out_ready, o_data, o_ovf                       |
// |             ovf_clr, ovf_cnt (only with FX_ADDSUB_OVF_CNT_EN)        |
// | Config    : FX_ADDSUB_OVF_CNT_EN adds a saturating 16-bit count of   |
// |             emitted beats that carried any lane overflow.            |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module fx_addsub_pipe
   import fx_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int W_IN  = 12,
   parameter int W_OUT = 13,
   parameter int SHR   = 0,
   parameter int LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 op_sub,
   input  logic                 sat_en,
   input  logic [NCH*W_IN-1:0]  i_data_1,
   input  logic [NCH*W_IN-1:0]  i_data_2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NCH*W_OUT-1:0] o_data,
   output logic [NCH-1:0]       o_ovf
`ifdef FX_ADDSUB_OVF_CNT_EN
   ,
   input  logic                 ovf_clr,
   output logic [15:0]          ovf_cnt
`endif
);

   logic [NCH*W_OUT-1:0] w_res;
   logic [NCH-1:0]       w_ovf;
   logic                 w_adv;

   logic [LAT-1:0]       r_vld;
   logic [NCH*W_OUT-1:0] r_data [LAT];
   logic [NCH-1:0]       r_ovf  [LAT];

   generate
      for (genvar k = 0; k < NCH; k++) begin : g_lane
         fx_addsub_lane #(
            .W_IN  (W_IN),
            .W_OUT (W_OUT),
            .SHR   (SHR)
         ) u_lane (
            .i_a      (i_data_1[k*W_IN +: W_IN]),
            .i_b      (i_data_2[k*W_IN +: W_IN]),
            .i_sub    (op_sub),
            .i_sat_en (sat_en),
            .o_res    (w_res[k*W_OUT +: W_OUT]),
            .o_ovf    (w_ovf[k])
         );
      end
   endgenerate

   // Whole pipe moves together; it only freezes when the output beat is
   // being refused, so internal bubbles are kept rather than squeezed out.
   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < LAT; s++) begin
            r_vld[s]  <= 1'b0;
            r_data[s] <= '0;
            r_ovf[s]  <= '0;
         end
      end else if (w_adv) begin
         r_vld[0] <= in_valid;
         if (in_valid) begin
            r_data[0] <= w_res;
            r_ovf[0]  <= w_ovf;
         end
         // Payload only moves behind a valid beat so bubbles don't toggle it.
         for (int s = 1; s < LAT; s++) begin
            r_vld[s] <= r_vld[s-1];
            if (r_vld[s-1]) begin
               r_data[s] <= r_data[s-1];
               r_ovf[s]  <= r_ovf[s-1];
            end
         end
      end
   end

   assign out_valid = r_vld[LAT-1];
   assign o_data    = r_data[LAT-1];
   assign o_ovf     = r_ovf[LAT-1];

`ifdef FX_ADDSUB_OVF_CNT_EN
   logic [15:0] r_ovf_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf_cnt <= 16'h0000;
      end else if (ovf_clr) begin
         r_ovf_cnt <= 16'h0000;
      end else if (out_valid && out_ready && (|o_ovf) && (r_ovf_cnt != 16'hFFFF)) begin
         r_ovf_cnt <= r_ovf_cnt + 16'h0001;
      end
   end

   assign ovf_cnt = r_ovf_cnt;
`endif

endmodule
`default_nettype wire
